display_scan_mux: RTL

DISPLAY_SCAN_MUX -- requirements
Module: display_scan_mux

---
 rtl/display_scan_mux_pkg.sv | 41 ++++
 rtl/bin2bcd_seq.sv | 96 +++++++++
 rtl/display_scan_mux.sv | 106 ++++++++++
 3 files changed

// File: rtl/display_scan_mux_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module  : display_scan_mux_pkg                                          |
// | Brief   : Shared constants, conversion state enum and BCD helpers for   |
// |           the multiplexed 4-digit display driver.                       |
// | Rev     : 1.0 - initial release                                         |
// ---------------------------------------------------------------------------
package display_scan_mux_pkg;

  localparam int DIGITS  = 4;
  localparam int MAX_VAL = 9999;
  localparam int BCD_W   = 4 * DIGITS;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } conv_state_e;

  // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift.
  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] res;
    res = bcd;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd[d*4 +: 4] >= 4'd5) begin
        res[d*4 +: 4] = bcd[d*4 +: 4] + 4'd3;
      end
    end
    return res;
  endfunction

  // True when the digit at position idx and every digit above it are zero.
  function automatic logic upper_digits_zero(input logic [BCD_W-1:0] bcd,
                                             input logic [1:0]       idx);
    logic [BCD_W-1:0] upper;
    upper = bcd >> {idx, 2'b00};
    return (upper == '0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module  : bin2bcd_seq                                                   |
// | Brief   : Sequential double-dabble converter, one bit per clock.        |
// |           IDLE -> SHIFT (BIN_W cycles) -> COMMIT (1 cycle) -> IDLE.     |
// | Rev     : 1.0 - initial release                                         |
// ---------------------------------------------------------------------------
module bin2bcd_seq
  import display_scan_mux_pkg::*;
#(
  parameter int BIN_W = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  localparam int CNT_W = $clog2(BIN_W + 1);

  conv_state_e      state_q, state_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [BCD_W-1:0] adj;

  // Next-state logic: capture on start, shift BIN_W times, then flag done.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    adj     = dabble_adjust(bcd_q);
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SHIFT;
          bin_d   = bin;
          bcd_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      ST_SHIFT: begin
        {bcd_d, bin_d} = {adj, bin_q} << 1;
        cnt_d          = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BIN_W - 1)) begin
          state_d = ST_COMMIT;
          done_d  = 1'b1;
        end
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any conversion in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;

endmodule
`default_nettype wire

// File: rtl/display_scan_mux.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module  : display_scan_mux                                              |
// | Brief   : Converts a saturated binary value to 4 BCD digits and scans   |
// |           them onto a multiplexed 7-segment display with leading-zero   |
// |           blanking.                                                     |
// | Rev     : 1.0 - initial release                                         |
// ---------------------------------------------------------------------------
module display_scan_mux
  import display_scan_mux_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int BIN_W       = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BIN_W-1:0] bin_in,
  input  logic             load,
  output logic             busy,
  output logic             ovf,
  output logic [3:0]       nibble,
  output logic [3:0]       an
);

  localparam int RCNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  // Comparison width wide enough to hold both bin_in and MAX_VAL.
  localparam int CMP_W  = (BIN_W > 14) ? BIN_W : 14;

  logic [CMP_W-1:0]  bin_ext;
  logic              over;
  logic [BIN_W-1:0]  bin_sat;
  logic              start;
  logic              conv_busy;
  logic              conv_done;
  logic [BCD_W-1:0]  conv_bcd;

  logic [BCD_W-1:0]  display_q, display_d;
  logic              ovf_q, ovf_d;
  logic [RCNT_W-1:0] rcnt_q, rcnt_d;
  logic [1:0]        idx_q, idx_d;
  logic [3:0]        an_q, an_d;
  logic [3:0]        nibble_q, nibble_d;

  // Saturate to the largest 4-digit value; loads are dropped while converting.
  assign bin_ext = CMP_W'(bin_in);
  assign over    = (bin_ext > CMP_W'(MAX_VAL));
  assign bin_sat = over ? BIN_W'(MAX_VAL) : bin_in;
  assign start   = load & ~conv_busy;

  bin2bcd_seq #(
    .BIN_W (BIN_W)
  ) u_bin2bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bin   (bin_sat),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  // Display update, free-running scan and output decode from next-state values
  // so an/nibble always match the index and display held in the registers.
  always_comb begin
    display_d = conv_done ? conv_bcd : display_q;
    ovf_d     = start ? over : ovf_q;
    if (rcnt_q == RCNT_W'(REFRESH_DIV - 1)) begin
      rcnt_d = '0;
      idx_d  = idx_q + 2'd1;
    end else begin
      rcnt_d = rcnt_q + RCNT_W'(1);
      idx_d  = idx_q;
    end
    nibble_d = display_d[{idx_d, 2'b00} +: 4];
    an_d     = ~(4'b0001 << idx_d);
    if ((idx_d != 2'd0) && upper_digits_zero(display_d, idx_d)) begin
      an_d = 4'b1111;
    end
  end

  // Scan and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      display_q <= '0;
      ovf_q     <= 1'b0;
      rcnt_q    <= '0;
      idx_q     <= 2'd0;
      an_q      <= 4'b1110;
      nibble_q  <= 4'h0;
    end else begin
      display_q <= display_d;
      ovf_q     <= ovf_d;
      rcnt_q    <= rcnt_d;
      idx_q     <= idx_d;
      an_q      <= an_d;
      nibble_q  <= nibble_d;
    end
  end

  assign busy   = conv_busy;
  assign ovf    = ovf_q;
  assign an     = an_q;
  assign nibble = nibble_q;

endmodule
`default_nettype wire
